bus32_epc_master: RTL

- Upstream bus master for bus32 register cells.
- Converts a single-outstanding command/response valid-ready interface into EPC-style accesses: address, byte enables, active-low chip select, write strobe and read strobe. Completion is signalled by ready from the slave.
- Sits between a host-side command source (UART/SPI decoder, soft CPU) and one or more bus32 slave cells. Includes a wait timeout so a dead slave cannot hang the host.

---
 rtl/bus32_epc_defs.sv | 17 +
 rtl/bus32_epc_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bus32_epc_defs.sv
// Shared definitions for the bus32 EPC master: FSM states, default
// timeout, read-timeout filler data and the inactive EPC strobe level.
package bus32_epc_defs;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } epc_state_t;

    localparam int          DEFAULT_TIMEOUT = 255;
    localparam logic [31:0] ERROR_DATA      = 32'hDEAD_BEEF;
    localparam logic        STROBE_OFF      = 1'b1;

endpackage

// File: rtl/bus32_epc_master.sv
// Upstream bus master for bus32 register cells. Turns one outstanding
// command into an EPC access (address, byte enables, active-low chip
// select and read/write strobes), waits for the slave's ready and
// returns a response. A wait timeout keeps a dead slave from hanging
// the host.
module bus32_epc_master
    import bus32_epc_defs::*;
#(
    parameter int                    datawidth      = 32,
    parameter int                    addrwidth      = 8,
    parameter int                    timeout_cycles = DEFAULT_TIMEOUT,
    parameter logic [datawidth-1:0]  error_data     = ERROR_DATA
) (
    input  logic                     clock_in,
    input  logic                     reset_in,

    input  logic                     cmd_valid_in,
    output logic                     cmd_ready_out,
    input  logic                     cmd_write_in,
    input  logic [addrwidth-1:0]     cmd_addr_in,
    input  logic [datawidth-1:0]     cmd_data_in,
    input  logic [datawidth/8-1:0]   cmd_be_in,

    output logic                     rsp_valid_out,
    input  logic                     rsp_ready_in,
    output logic [datawidth-1:0]     rsp_data_out,
    output logic                     rsp_error_out,

    output logic [addrwidth-1:0]     epc_addr_out,
    output logic [datawidth-1:0]     epc_data_out,
    input  logic [datawidth-1:0]     epc_data_in,
    output logic [datawidth/8-1:0]   epc_be_out,
    output logic                     epc_cs_n_out,
    output logic                     epc_wr_n_out,
    output logic                     epc_rd_n_out,
    input  logic                     epc_rdy_in,

    output logic                     busy_out
);

    localparam int        BEWIDTH    = datawidth / 8;
    localparam logic [7:0] TIMEOUT_CNT = 8'(timeout_cycles);

    epc_state_t              state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [addrwidth-1:0]    addr_q, addr_d;
    logic [datawidth-1:0]    wdata_q, wdata_d;
    logic [BEWIDTH-1:0]      be_q, be_d;
    logic                    cs_n_q, cs_n_d;
    logic                    wr_n_q, wr_n_d;
    logic                    rd_n_q, rd_n_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [datawidth-1:0]    rsp_data_q, rsp_data_d;
    logic                    rsp_error_q, rsp_error_d;
    logic [7:0]              cnt_inc;
    logic                    cmd_fire;

    assign cmd_ready_out = (state_q == IDLE) && !reset_in;
    assign cmd_fire      = cmd_valid_in && cmd_ready_out;
    assign cnt_inc       = cnt_q + 8'd1;

    // Next-state and next-register-value logic for the access sequence.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the case statement leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cs_n_d      = cs_n_q;
        wr_n_d      = wr_n_q;
        rd_n_d      = rd_n_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            IDLE: begin
                cs_n_d = STROBE_OFF;
                wr_n_d = STROBE_OFF;
                rd_n_d = STROBE_OFF;
                if (cmd_fire) begin
                    write_d = cmd_write_in;
                    addr_d  = cmd_addr_in;
                    wdata_d = cmd_data_in;
                    be_d    = cmd_be_in;
                    cs_n_d  = !STROBE_OFF;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                // Chip select has been low for one cycle; open the strobe.
                cs_n_d  = !STROBE_OFF;
                wr_n_d  = !write_q;
                rd_n_d  = write_q;
                state_d = ACCESS;
            end

            ACCESS: begin
                cnt_d = cnt_inc;
                // Ready is checked before the timeout so a ready arriving
                // on the final count is reported as a success.
                if (epc_rdy_in) begin
                    cs_n_d = STROBE_OFF;
                    wr_n_d = STROBE_OFF;
                    rd_n_d = STROBE_OFF;
                    if (write_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b0;
                        state_d     = RESP;
                    end else begin
                        state_d = CAPTURE;
                    end
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    cs_n_d      = STROBE_OFF;
                    wr_n_d      = STROBE_OFF;
                    rd_n_d      = STROBE_OFF;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = write_q ? '0 : error_data;
                    rsp_error_d = 1'b1;
                    state_d     = RESP;
                end
            end

            CAPTURE: begin
                // The slave registers read data on its ready edge, so the
                // bus is valid during this cycle.
                rsp_valid_d = 1'b1;
                rsp_data_d  = epc_data_in;
                rsp_error_d = 1'b0;
                state_d     = RESP;
            end

            RESP: begin
                if (rsp_ready_in) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end

            default: begin
                cs_n_d      = STROBE_OFF;
                wr_n_d      = STROBE_OFF;
                rd_n_d      = STROBE_OFF;
                rsp_valid_d = 1'b0;
                cnt_d       = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clock_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the clock edge.
        if (reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, EPC output and response registers with synchronous reset.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            cs_n_q      <= STROBE_OFF;
            wr_n_q      <= STROBE_OFF;
            rd_n_q      <= STROBE_OFF;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign epc_addr_out  = addr_q;
    assign epc_data_out  = wdata_q;
    assign epc_be_out    = be_q;
    assign epc_cs_n_out  = cs_n_q;
    assign epc_wr_n_out  = wr_n_q;
    assign epc_rd_n_out  = rd_n_q;
    assign rsp_valid_out = rsp_valid_q;
    assign rsp_data_out  = rsp_data_q;
    assign rsp_error_out = rsp_error_q;
    assign busy_out      = (state_q != IDLE);

endmodule
